// File: rtl/bytecode_prefetch_pkg.sv
// Shared machine constants and bundles for the bytecode prefetch unit.
// Prefetch FSM state encoding plus the FIFO control bundle.
package bytecode_prefetch_pkg;

  localparam int PF_STATE_W = 2;

  typedef enum logic [PF_STATE_W-1:0] {
    PF_IDLE  = 2'd0,
    PF_FETCH = 2'd1,
    PF_FLUSH = 2'd2
  } pf_state_e;

  typedef struct packed {
    logic push;
    logic pop;
    logic flush;
  } fifo_ctl_t;

endpackage

// File: rtl/bytecode_prefetch_fifo.sv
// Small synchronous byte FIFO for prefetched bytecode.
// Flush dominates push/pop; head reads 0 when empty.
module prefetch_fifo #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [7:0]       din,
  output logic [7:0]       dout,
  output logic [CNT_W-1:0] count
);

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] rptr;
  logic [PTR_W-1:0] wptr;
  logic             empty;
  logic             full;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign push_ok = push & ~full & ~flush;
  assign pop_ok  = pop & ~empty & ~flush;
  assign dout    = empty ? 8'h00 : mem[rptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else if (flush) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + PTR_W'(1);
      if (pop_ok)  rptr <= rptr + PTR_W'(1);
      if (push_ok && !pop_ok)
        count <= count + CNT_W'(1);
      else if (pop_ok && !push_ok)
        count <= count - CNT_W'(1);
    end
  end

  // Storage needs no reset: reads are masked while empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= din;
  end

endmodule

// File: rtl/bytecode_prefetch.sv
// Bytecode prefetch stage: owns the bytecode PC, fetches over req/ack
// into a small FIFO and presents one byte at a time to the sequencer.
module bytecode_prefetch
  import bytecode_prefetch_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_pc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              consume,
  output logic [7:0]        iram_data,
  output logic              waiting,
  output logic [ADDR_W-1:0] byte_pc,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic              active
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  pf_state_e         state_q;
  pf_state_e         state_d;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] fetch_d;
  logic [ADDR_W-1:0] byte_d;
  logic [ADDR_W-1:0] pend_pc;
  logic [ADDR_W-1:0] pend_d;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              xfer;
  fifo_ctl_t         ctl;

  assign fifo_full = (fifo_count == CNT_W'(DEPTH));
  assign waiting   = (fifo_count == '0);
  assign active    = (state_q != PF_IDLE);
  assign mem_addr  = fetch_pc;
  assign xfer      = mem_req & mem_ack;

  // FLUSH keeps the abandoned request alive until the memory acks it.
  assign mem_req = ((state_q == PF_FETCH) && !fifo_full) ||
                   (state_q == PF_FLUSH);

  always_comb begin
    state_d = state_q;
    fetch_d = fetch_pc;
    byte_d  = byte_pc;
    pend_d  = pend_pc;
    ctl     = '0;
    unique case (state_q)
      PF_IDLE: begin
        if (start) begin
          state_d   = PF_FETCH;
          fetch_d   = start_pc;
          byte_d    = start_pc;
          ctl.flush = 1'b1;
        end
      end
      PF_FETCH: begin
        if (redirect) begin
          ctl.flush = 1'b1;
          byte_d    = redirect_pc;
          if (!mem_req || mem_ack) begin
            fetch_d = redirect_pc;
          end else begin
            pend_d  = redirect_pc;
            state_d = PF_FLUSH;
          end
        end else begin
          if (xfer) begin
            ctl.push = 1'b1;
            fetch_d  = fetch_pc + ADDR_W'(1);
          end
          if (consume && !waiting) begin
            ctl.pop = 1'b1;
            byte_d  = byte_pc + ADDR_W'(1);
          end
        end
      end
      PF_FLUSH: begin
        if (redirect) begin
          ctl.flush = 1'b1;
          byte_d    = redirect_pc;
          if (mem_ack) begin
            fetch_d = redirect_pc;
            state_d = PF_FETCH;
          end else begin
            pend_d  = redirect_pc;
          end
        end else if (mem_ack) begin
          fetch_d = pend_pc;
          state_d = PF_FETCH;
        end
      end
      default: state_d = PF_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= PF_IDLE;
      fetch_pc <= '0;
      byte_pc  <= '0;
      pend_pc  <= '0;
    end else begin
      state_q  <= state_d;
      fetch_pc <= fetch_d;
      byte_pc  <= byte_d;
      pend_pc  <= pend_d;
    end
  end

  prefetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (ctl.push),
    .pop   (ctl.pop),
    .flush (ctl.flush),
    .din   (mem_rdata),
    .dout  (iram_data),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_bytecode_prefetch.sv
// Randomised bench for bytecode_prefetch against a queue-based model
// with a variable-latency memory responder.
module tb_bytecode_prefetch;

  localparam int ADDR_W = 16;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] start_pc = '0;
  logic              redirect = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;
  logic              consume = 1'b0;
  logic [7:0]        iram_data;
  logic              waiting;
  logic [ADDR_W-1:0] byte_pc;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack = 1'b0;
  logic [7:0]        mem_rdata = '0;
  logic              active;

  bytecode_prefetch #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .start_pc    (start_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .consume     (consume),
    .iram_data   (iram_data),
    .waiting     (waiting),
    .byte_pc     (byte_pc),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .active      (active)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  // Model: 0 idle, 1 running, 2 draining an abandoned request.
  int              m_mode;
  logic [15:0]     m_fetch;
  logic [15:0]     m_bpc;
  logic [15:0]     m_pend;
  logic [7:0]      q[$];
  int              lat;
  int              wcnt;
  int              maxlat;
  bit              rnd_lat;

  function automatic logic [7:0] mem_f(input logic [15:0] a);
    return a[7:0];
  endfunction

  function automatic bit m_req();
    return (m_mode == 1 && q.size() < DEPTH) || m_mode == 2;
  endfunction

  task automatic model_reset();
    m_mode  = 0;
    m_fetch = '0;
    m_bpc   = '0;
    m_pend  = '0;
    q.delete();
    wcnt    = 0;
  endtask

  task automatic check_outputs();
    check("active",    32'(active),    32'(m_mode != 0));
    check("mem_req",   32'(mem_req),   32'(m_req()));
    check("mem_addr",  32'(mem_addr),  32'(m_fetch));
    check("waiting",   32'(waiting),   32'(q.size() == 0));
    check("iram_data", 32'(iram_data),
          (q.size() != 0) ? 32'(q[0]) : 32'd0);
    check("byte_pc",   32'(byte_pc),   32'(m_bpc));
  endtask

  task automatic model_update(input bit st, input logic [15:0] spc,
                              input bit rd, input logic [15:0] rpc,
                              input bit cons, input bit req,
                              input bit ack, input logic [7:0] rdata);
    case (m_mode)
      0: if (st) begin
        m_mode = 1; m_fetch = spc; m_bpc = spc; q.delete();
      end
      1: if (rd) begin
        q.delete();
        m_bpc = rpc;
        if (!req || ack) m_fetch = rpc;
        else begin m_pend = rpc; m_mode = 2; end
      end else begin
        if (cons && q.size() > 0) begin
          void'(q.pop_front());
          m_bpc = m_bpc + 16'd1;
        end
        if (req && ack) begin
          q.push_back(rdata);
          m_fetch = m_fetch + 16'd1;
        end
      end
      default: if (rd) begin
        m_bpc = rpc;
        if (ack) begin m_fetch = rpc; m_mode = 1; end
        else m_pend = rpc;
      end else if (ack) begin
        m_fetch = m_pend; m_mode = 1;
      end
    endcase
  endtask

  task automatic step(input bit st, input logic [15:0] spc,
                      input bit rd, input logic [15:0] rpc,
                      input bit cons);
    bit req;
    bit ack;
    check_outputs();
    req = m_req();
    ack = req && (wcnt >= lat);
    start       = st;
    start_pc    = spc;
    redirect    = rd;
    redirect_pc = rpc;
    consume     = cons;
    mem_ack     = ack;
    mem_rdata   = ack ? mem_f(m_fetch) : 8'($urandom);
    @(posedge clk);
    model_update(st, spc, rd, rpc, cons, req, ack, mem_rdata);
    if (!req) wcnt = 0;
    else if (ack) begin
      wcnt = 0;
      if (rnd_lat) lat = $urandom_range(0, maxlat);
    end else wcnt++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    start = 1'b0; redirect = 1'b0; consume = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    bit found;
    model_reset();
    lat = 0; rnd_lat = 0; maxlat = 3;
    repeat (2) @(negedge clk);
    check_outputs();
    reset = 1'b1;

    // zero-wait streaming from 0x0010
    step(1, 16'h0010, 0, 0, 1);
    repeat (12) step(0, 0, 0, 0, 1);

    // fill without consuming, then one consume pulse
    do_reset();
    step(1, 16'h0010, 0, 0, 0);
    repeat (8) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    repeat (4) step(0, 0, 0, 0, 0);

    // redirect in 2nd wait cycle of request 0x0012, 3-cycle memory
    do_reset();
    lat = 3;
    step(1, 16'h0010, 0, 0, 1);
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (m_mode == 1 && m_fetch == 16'h0012 && wcnt == 1) found = 1;
      else step(0, 0, 0, 0, 1);
    end
    check("redir_point", 32'(found), 32'd1);
    step(0, 0, 1, 16'h0200, 1);
    repeat (16) step(0, 0, 0, 0, 1);

    // redirect coinciding with ack and consume
    do_reset();
    lat = 0;
    step(1, 16'h0040, 0, 0, 1);
    repeat (4) step(0, 0, 0, 0, 1);
    step(0, 0, 1, 16'h0123, 1);
    repeat (5) step(0, 0, 0, 0, 1);

    // address wrap
    do_reset();
    step(1, 16'hFFFE, 0, 0, 1);
    repeat (8) step(0, 0, 0, 0, 1);

    // randomised traffic
    do_reset();
    rnd_lat = 1;
    lat = $urandom_range(0, maxlat);
    step(1, 16'($urandom), 0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 50) == 0, 16'($urandom),
           ($urandom % 16) == 0, 16'($urandom),
           ($urandom % 4) != 0);
    end

    // asynchronous reset while a request is outstanding
    do_reset();
    rnd_lat = 0; lat = 1;
    step(1, 16'h0080, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0);
    check("pre_rst_req", 32'(m_req()), 32'd1);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) step(0, 0, 1, 16'h0055, 1);
    step(1, 16'h0090, 0, 0, 1);
    repeat (6) step(0, 0, 0, 0, 1);
    check_outputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
